// File: rtl/fp_divider_if.sv
// Start/busy/done handshake and result bundle for the binary32 divider.
// The master drives a request; the slave returns the quotient and exception flags.
interface fp_divider_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inf;
    logic        nan;
    logic        dz;

    modport master (
        output start, a, b,
        input  busy, done, result, overflow, underflow, inf, nan, dz
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, overflow, underflow, inf, nan, dz
    );
endinterface

// File: rtl/fp_divider.sv
// Iterative binary32 divider: restoring radix-2, one quotient bit per cycle, FTZ in/out.
// FP_DIV_ROUND_EN selects round-to-nearest-even; otherwise truncate with saturating overflow.
module fp_divider (
    input  logic         clk,
    input  logic         rst,
    fp_divider_if.slave  bus
);

`ifdef FP_DIV_ROUND_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_NORM, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic               spec_q, spec_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [24:0]        rem_q, rem_d;
    logic [23:0]        div_q, div_d;
    logic [25:0]        quo_q, quo_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        result_q, result_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               ovf_q, ovf_d, unf_q, unf_d, inf_q, inf_d, nan_q, nan_d, dz_q, dz_d;

    // Operand classification after flush-to-zero of exponent-0 inputs.
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    assign a_zero = (a_q[30:23] == 8'h00);
    assign b_zero = (b_q[30:23] == 8'h00);
    assign a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'h0);
    assign b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'h0);
    assign a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'h0);
    assign b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'h0);

    logic [25:0] diff;
    assign diff = {1'b0, rem_q} - {2'b00, div_q};

    // Normalisation and rounding of the finished quotient.
    logic [23:0]       mant_n;
    logic              guard_n, sticky_n, round_inc;
    logic signed [9:0] exp_n, exp_f;
    logic [24:0]       mant_r;
    logic [22:0]       frac_f;
    logic [31:0]       norm_res;
    logic              norm_ovf, norm_unf, norm_inf;

    always_comb begin
        mant_n   = quo_q[24:1];
        guard_n  = quo_q[0];
        sticky_n = |rem_q;
        exp_n    = exp_q - 10'sd1;
        if (quo_q[25]) begin
            mant_n   = quo_q[25:2];
            guard_n  = quo_q[1];
            sticky_n = quo_q[0] | (|rem_q);
            exp_n    = exp_q;
        end
        round_inc = RNE & guard_n & (sticky_n | mant_n[0]);
        mant_r    = {1'b0, mant_n} + {24'h0, round_inc};
        frac_f    = mant_r[22:0];
        exp_f     = exp_n;
        if (mant_r[24]) begin
            frac_f = mant_r[23:1];
            exp_f  = exp_n + 10'sd1;
        end
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        norm_inf = 1'b0;
        norm_res = {sign_q, exp_f[7:0], frac_f};
        if (exp_f >= 10'sd255) begin
            norm_ovf = 1'b1;
`ifdef FP_DIV_ROUND_EN
            norm_inf = 1'b1;
            norm_res = {sign_q, 8'hFF, 23'h0};
`else
            norm_res = {sign_q, 31'h7F7FFFFF};
`endif
        end else if (exp_f <= 10'sd0) begin
            norm_unf = 1'b1;
            norm_res = {sign_q, 31'h0};
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        spec_d   = spec_q;
        exp_d    = exp_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inf_d    = inf_q;
        nan_d    = nan_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    busy_d  = 1'b1;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    inf_d   = 1'b0;
                    nan_d   = 1'b0;
                    dz_d    = 1'b0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sign_d  = a_q[31] ^ b_q[31];
                spec_d  = 1'b1;
                // Special results are registered here and ride through NORM untouched.
                state_d = S_NORM;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    result_d = 32'h7FC00000;
                    nan_d    = 1'b1;
                end else if (a_inf) begin
                    result_d = {a_q[31] ^ b_q[31], 8'hFF, 23'h0};
                    inf_d    = 1'b1;
                end else if (b_zero) begin
                    result_d = {a_q[31] ^ b_q[31], 8'hFF, 23'h0};
                    inf_d    = 1'b1;
                    dz_d     = 1'b1;
                end else if (b_inf || a_zero) begin
                    result_d = {a_q[31] ^ b_q[31], 31'h0};
                end else begin
                    spec_d  = 1'b0;
                    rem_d   = {2'b01, a_q[22:0]};
                    div_d   = {1'b1, b_q[22:0]};
                    exp_d   = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
                    quo_d   = 26'h0;
                    cnt_d   = 5'd0;
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                rem_d = (diff[25] ? rem_q : diff[24:0]) << 1;
                quo_d = {quo_q[24:0], ~diff[25]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25)
                    state_d = S_NORM;
            end
            S_NORM: begin
                if (!spec_q) begin
                    result_d = norm_res;
                    ovf_d    = norm_ovf;
                    unf_d    = norm_unf;
                    inf_d    = norm_inf;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            sign_q   <= 1'b0;
            spec_q   <= 1'b0;
            exp_q    <= 10'sd0;
            rem_q    <= 25'h0;
            div_q    <= 24'h0;
            quo_q    <= 26'h0;
            cnt_q    <= 5'd0;
            result_q <= 32'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inf_q    <= 1'b0;
            nan_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            spec_q   <= spec_d;
            exp_q    <= exp_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inf_q    <= inf_d;
            nan_q    <= nan_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.inf       = inf_q;
    assign bus.nan       = nan_q;
    assign bus.dz        = dz_q;

endmodule
